bk_mp_add_seq: RTL and testbench

Multi-precision add/subtract sequencer built on one shared N-bit Brent-Kung slice adder. It accepts W = N*WORDS-bit operands and processes one N-bit slice per clock, LSB slice first, chaining the slice carry-out into the next slice's carry-in. It sits between a wide-operand producer (start/done handshake) and consumers that tolerate multi-cycle latency in exchange for a small adder.

---
 rtl/bk_pkg.sv | 18 +
 rtl/bk_slice_adder.sv | 51 +++++
 rtl/bk_mp_add_seq.sv | 117 +++++++++++
 tb/tb_bk_mp_add_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared constants, FSM state type and index-width helper for the
// multi-precision Brent-Kung add/subtract sequencer.
package bk_pkg;

    localparam int N_DEF     = 4;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/bk_slice_adder.sv
// Combinational N-bit Brent-Kung adder: PG cells, log-depth up-sweep of
// group generate/propagate, then a down-sweep filling in the odd prefixes.
module bk_slice_adder
    import bk_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N:0]   s
);

    localparam int LV = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] p_bit;
    logic [N-1:0] g_grp;
    logic [N-1:0] p_grp;

    assign p_bit = a ^ b;

    // After both sweeps g_grp[i] is the carry out of bit i (cin folded into bit 0).
    always_comb begin
        // NOTE: every variable gets a full default first so no path leaves a latch.
        g_grp = a & b;
        p_grp = p_bit;
        g_grp[0] = g_grp[0] | (p_grp[0] & cin);

        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i - (1 << l)]);
                    p_grp[i] = p_grp[i] & p_grp[i - (1 << l)];
                end
            end
        end

        for (int l = LV - 1; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (1 << l))) begin
                    g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[i - (1 << l)]);
                    p_grp[i] = p_grp[i] & p_grp[i - (1 << l)];
                end
            end
        end
    end

    assign s[N-1:0] = p_bit ^ {g_grp[N-2:0], cin};
    assign s[N]     = g_grp[N-1];

endmodule

// File: rtl/bk_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one N-bit slice per clock through a
// shared Brent-Kung adder, LSB slice first, carry chained between slices.
module bk_mp_add_seq
    import bk_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_sub,
    input  logic               cin,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q, b_q, acc_q, acc_d, sum_q;
    logic          carry_q, busy_q, done_q, cout_q, ovf_q;

    logic [N-1:0]  a_sl, b_sl;
    logic [N:0]    sl_s;
    logic          msb_cin;

    assign a_sl = a_q[int'(idx_q) * N +: N];
    assign b_sl = b_q[int'(idx_q) * N +: N];

    bk_slice_adder #(.N(N)) u_slice (
        .a   (a_sl),
        .b   (b_sl),
        .cin (carry_q),
        .s   (sl_s)
    );

    always_comb begin
        acc_d = acc_q;
        acc_d[int'(idx_q) * N +: N] = sl_s[N-1:0];
    end

    // Only meaningful on the top slice, where it is the carry into bit W-1.
    assign msb_cin = sl_s[N-1] ^ a_sl[N-1] ^ b_sl[N-1];

    // NOTE: operand/accumulator registers are reset too, so the outputs and
    // datapath never show X after reset; the cost is small at these widths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= sl_s[N];
                    if (idx_q == LAST) begin
                        sum_q   <= acc_d;
                        cout_q  <= sl_s[N];
                        ovf_q   <= sl_s[N] ^ msb_cin;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bk_mp_add_seq.sv
// Self-checking bench for bk_mp_add_seq: expected results are queued when an
// operation is started and compared when done pulses.
module tb_bk_mp_add_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, op_sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int           n_checks = 0;
    int           n_errors = 0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] last_sum = '0;

    bk_mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mcin);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb     = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ma[W-1] == bb[W-1]) && (e.sum[W-1] != ma[W-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sum",  32'(sum),  32'(mon_e.sum));
                check("cout", 32'(cout), 32'(mon_e.cout));
                check("ovf",  32'(ovf),  32'(mon_e.ovf));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic tsub, input logic tcin, input bit restart);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        @(negedge clk);
        a = ta; b = tb2; op_sub = tsub; cin = tcin; start = 1'b1;
        e = model(ta, tb2, tsub, tcin);
        sb.push_back(e);
        cyc = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (restart && cyc == 2) begin
                start = 1'b1; a = '1; b = '1; op_sub = 1'b0; cin = 1'b1;
            end
            if (restart && cyc == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (!done) check("sum_stable", 32'(sum), 32'(last_sum));
        end while (!done && cyc < 20);
        check("latency", 32'(cyc), 32'(WORDS + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(WORDS + 1));
        last_sum = e.sum;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h000F, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

        // Second start while busy must be ignored.
        run_op(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_second_done", 32'(done), 32'd0);
        end
        check("ignored_sum", 32'(sum), 32'h2222);

        // Asynchronous reset two edges into an operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum",  32'(sum),  32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf",  32'(ovf),  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        last_sum = '0;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
